// File: rtl/cdb_arbiter.sv
// Common Data Bus producer: per-source one-deep result holding registers feeding a
// round-robin arbiter that drives one registered broadcast per cycle.
module cdb_arbiter #(
  parameter int N_SRC  = 4,
  parameter int TAG_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic [N_SRC-1:0]          src_valid_i,
  input  logic [N_SRC*TAG_W-1:0]    src_tag_i,
  input  logic [N_SRC*DATA_W-1:0]   src_data_i,
  output logic [N_SRC-1:0]          src_ready_o,
  output logic [N_SRC-1:0]          src_taken_o,
  output logic [TAG_W+DATA_W:0]     cdb_o
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CDB_W = 1 + TAG_W + DATA_W;

  logic [N_SRC-1:0]             hold_v_q, hold_v_d;
  logic [N_SRC-1:0][TAG_W-1:0]  hold_tag_q;
  logic [N_SRC-1:0][DATA_W-1:0] hold_data_q;
  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [CDB_W-1:0]             cdb_q, cdb_d;
  logic [N_SRC-1:0]             taken_q, taken_d;

  logic [N_SRC-1:0]             grant;
  logic [PTR_W-1:0]             gidx;
  logic                         any_grant;
  logic [N_SRC-1:0]             accept;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_SRC) s = s - N_SRC;
    return PTR_W'(s);
  endfunction

  // Arbitration looks only at registered hold state, never at same-cycle offers.
  always_comb begin
    grant     = '0;
    gidx      = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!any_grant && hold_v_q[ptr_add(rr_ptr_q, k)]) begin
        any_grant                   = 1'b1;
        gidx                        = ptr_add(rr_ptr_q, k);
        grant[ptr_add(rr_ptr_q, k)] = 1'b1;
      end
    end
  end

  assign src_ready_o = ~hold_v_q | grant;

  // Tag-0 offers complete the handshake but never occupy a slot.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_SRC; i++) begin
      accept[i] = src_valid_i[i] & src_ready_o[i] & ~flush_i &
                  (src_tag_i[i*TAG_W +: TAG_W] != '0);
    end
  end

  always_comb begin
    hold_v_d = hold_v_q;
    rr_ptr_d = rr_ptr_q;
    cdb_d    = '0;
    taken_d  = '0;
    if (flush_i) begin
      hold_v_d = '0;
    end else begin
      hold_v_d = (hold_v_q & ~grant) | accept;
      if (any_grant) begin
        cdb_d    = {1'b1, hold_tag_q[gidx], hold_data_q[gidx]};
        taken_d  = grant;
        rr_ptr_d = ptr_add(gidx, 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_v_q <= '0;
      rr_ptr_q <= '0;
      cdb_q    <= '0;
      taken_q  <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
      taken_q  <= taken_d;
    end
  end

  // Payload registers carry no reset; hold_v_q qualifies them.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (accept[i]) begin
        hold_tag_q[i]  <= src_tag_i[i*TAG_W +: TAG_W];
        hold_data_q[i] <= src_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cdb_o       = cdb_q;
  assign src_taken_o = taken_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, contention, streaming,
// flush, tag-0 discard and mid-operation reset.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [3:0]   src_valid;
  logic [31:0]  src_tag;
  logic [127:0] src_data;
  logic [3:0]   src_ready;
  logic [3:0]   src_taken;
  logic [40:0]  cdb;

  int vectors = 0;
  int miscompares = 0;

  cdb_arbiter #(.N_SRC(4), .TAG_W(8), .DATA_W(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .src_valid_i (src_valid),
    .src_tag_i   (src_tag),
    .src_data_i  (src_data),
    .src_ready_o (src_ready),
    .src_taken_o (src_taken),
    .cdb_o       (cdb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [40:0] exp_cdb, input logic [3:0] exp_taken);
    chk({name, ".cdb"}, {23'd0, cdb}, {23'd0, exp_cdb});
    chk({name, ".taken"}, {60'd0, src_taken}, {60'd0, exp_taken});
  endtask

  task automatic clr();
    src_valid = '0;
    src_tag   = '0;
    src_data  = '0;
    flush     = 1'b0;
  endtask

  task automatic offer(input int i, input logic [7:0] tag, input logic [31:0] data);
    src_valid[i]         = 1'b1;
    src_tag[i*8 +: 8]    = tag;
    src_data[i*32 +: 32] = data;
  endtask

  task automatic drop(input int i);
    src_valid[i] = 1'b0;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;

    // Reset with all sources offering
    offer(0, 8'h11, 32'h1); offer(1, 8'h12, 32'h2);
    offer(2, 8'h13, 32'h3); offer(3, 8'h14, 32'h4);
    tick();
    chk_out("reset", 41'h0, 4'b0000);
    chk("reset.ready", {60'd0, src_ready}, 64'hF);
    rst_n = 1'b1;
    clr();
    tick();
    chk_out("reset_post1", 41'h0, 4'b0000);
    tick();
    chk_out("reset_post2", 41'h0, 4'b0000);

    // Single result
    offer(0, 8'h05, 32'hDEADBEEF);
    tick();
    chk_out("single_hold", 41'h0, 4'b0000);
    clr();
    tick();
    chk_out("single_bcast", {1'b1, 8'h05, 32'hDEADBEEF}, 4'b0001);
    tick();
    chk_out("single_after", 41'h0, 4'b0000);

    // Contention from rr_ptr = 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    offer(0, 8'h01, 32'hA0); offer(1, 8'h02, 32'hA1);
    offer(2, 8'h03, 32'hA2); offer(3, 8'h04, 32'hA3);
    tick();
    chk_out("cont_hold", 41'h0, 4'b0000);
    clr();
    tick();
    chk_out("cont_g0", {1'b1, 8'h01, 32'hA0}, 4'b0001);
    tick();
    chk_out("cont_g1", {1'b1, 8'h02, 32'hA1}, 4'b0010);
    tick();
    chk_out("cont_g2", {1'b1, 8'h03, 32'hA2}, 4'b0100);
    tick();
    chk_out("cont_g3", {1'b1, 8'h04, 32'hA3}, 4'b1000);
    tick();
    chk_out("cont_idle", 41'h0, 4'b0000);

    // Streaming src2 against src0; rr_ptr wrapped to 0
    offer(0, 8'h10, 32'hB0); offer(2, 8'h20, 32'hC0);
    tick();
    chk_out("strm_load", 41'h0, 4'b0000);
    drop(0); offer(2, 8'h21, 32'hC1);
    chk("strm_ready_bp1", {60'd0, src_ready}, 64'hB);
    tick();
    chk_out("strm_b0", {1'b1, 8'h10, 32'hB0}, 4'b0001);
    offer(0, 8'h11, 32'hB1);
    chk("strm_ready_drain", {60'd0, src_ready}, 64'hF);
    tick();
    chk_out("strm_b1", {1'b1, 8'h20, 32'hC0}, 4'b0100);
    drop(0); offer(2, 8'h22, 32'hC2);
    chk("strm_ready_bp2", {60'd0, src_ready}, 64'hB);
    tick();
    chk_out("strm_b2", {1'b1, 8'h11, 32'hB1}, 4'b0001);
    tick();
    chk_out("strm_b3", {1'b1, 8'h21, 32'hC1}, 4'b0100);
    clr();
    tick();
    chk_out("strm_b4", {1'b1, 8'h22, 32'hC2}, 4'b0100);
    tick();
    chk_out("strm_idle", 41'h0, 4'b0000);

    // Flush with three pending; rr_ptr is 3 here
    offer(0, 8'h30, 32'hD0); offer(1, 8'h31, 32'hD1); offer(3, 8'h33, 32'hD3);
    tick();
    chk_out("flush_load", 41'h0, 4'b0000);
    clr();
    flush = 1'b1;
    offer(1, 8'h3F, 32'hDF); offer(2, 8'h3E, 32'hDE);
    tick();
    chk_out("flush_edge", 41'h0, 4'b0000);
    chk("flush_ready", {60'd0, src_ready}, 64'hF);
    clr();
    tick();
    chk_out("flush_post1", 41'h0, 4'b0000);
    tick();
    chk_out("flush_post2", 41'h0, 4'b0000);
    offer(0, 8'h40, 32'hE0); offer(3, 8'h43, 32'hE3);
    tick();
    clr();
    tick();
    chk_out("flush_rr3", {1'b1, 8'h43, 32'hE3}, 4'b1000);
    tick();
    chk_out("flush_rr0", {1'b1, 8'h40, 32'hE0}, 4'b0001);
    tick();
    chk_out("flush_idle", 41'h0, 4'b0000);

    // Tag 0 is accepted and discarded
    offer(3, 8'h00, 32'h1234);
    chk("tag0_ready", {60'd0, src_ready}, 64'hF);
    tick();
    clr();
    chk_out("tag0_e1", 41'h0, 4'b0000);
    tick();
    chk_out("tag0_e2", 41'h0, 4'b0000);
    tick();
    chk_out("tag0_e3", 41'h0, 4'b0000);

    // Reset while a result is pending
    offer(1, 8'h55, 32'hF1);
    tick();
    clr();
    rst_n = 1'b0;
    tick();
    chk_out("midrst", 41'h0, 4'b0000);
    rst_n = 1'b1;
    tick();
    chk_out("midrst_post1", 41'h0, 4'b0000);
    tick();
    chk_out("midrst_post2", 41'h0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
